icap_seq_ctrl: RTL and testbench

- Sequences the 7-series ICAPE2 primitive (32-bit port) for partial reconfiguration.
- Streams bitstream words from a valid/ready source into the ICAP with write-enable and RDWRB timing.
- After the last bitstream word it runs a fixed configuration-register command sequence: read STAT, then desync.
- Reports completion and CRC error to the PR/DFX controller; sits between the PR-bitstream DMA path and the ICAP instance wrapper.

---
 rtl/icap_pkg.sv | 41 ++++
 rtl/icap_cmd_rom.sv | 26 ++
 rtl/icap_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_icap_seq_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icap_pkg.sv
// Shared ICAPE2 command words, sequencer state type and ICAP byte bit-ordering helper.
// Imported by the sequencer and its command ROM.
package icap_pkg;

  localparam logic [31:0] ICAP_SYNC    = 32'hAA99_5566;
  localparam logic [31:0] ICAP_NOOP    = 32'h2000_0000;
  localparam logic [31:0] ICAP_RD_STAT = 32'h2800_E001;
  localparam logic [31:0] ICAP_WR_CMD  = 32'h3000_8001;
  localparam logic [31:0] ICAP_DESYNC  = 32'h0000_000D;

  localparam int ROM_IDX_W = 4;

  // ROM index ranges: CMD is 0..4, DSY is 5..8.
  localparam logic [ROM_IDX_W-1:0] CMD_FIRST = 4'd0;
  localparam logic [ROM_IDX_W-1:0] CMD_LAST  = 4'd4;
  localparam logic [ROM_IDX_W-1:0] DSY_FIRST = 4'd5;
  localparam logic [ROM_IDX_W-1:0] DSY_LAST  = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR,
    S_GAP,
    S_CMD,
    S_SW1,
    S_RD,
    S_SW2,
    S_DSY,
    S_FIN
  } state_t;

  function automatic logic [31:0] bitswap32(input logic [31:0] x);
    logic [31:0] y;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        y[8*b + i] = x[8*b + 7 - i];
      end
    end
    return y;
  endfunction

endpackage

// File: rtl/icap_cmd_rom.sv
// Index-to-word lookup for the post-bitstream command sequence (STAT read, then desync).
// Purely combinational; no flow control.
module icap_cmd_rom
  import icap_pkg::*;
(
  input  logic [ROM_IDX_W-1:0] idx,
  output logic [31:0]          word
);

  always_comb begin
    word = ICAP_NOOP;
    case (idx)
      4'd0:    word = ICAP_SYNC;
      4'd1:    word = ICAP_NOOP;
      4'd2:    word = ICAP_RD_STAT;
      4'd3:    word = ICAP_NOOP;
      4'd4:    word = ICAP_NOOP;
      4'd5:    word = ICAP_WR_CMD;
      4'd6:    word = ICAP_DESYNC;
      4'd7:    word = ICAP_NOOP;
      4'd8:    word = ICAP_NOOP;
      default: word = ICAP_NOOP;
    endcase
  end

endmodule

// File: rtl/icap_seq_ctrl.sv
// ICAPE2 partial-reconfiguration sequencer: streams bitstream words, reads STAT, desyncs.
// All outputs registered; done 14+READ_LAT cycles after the last beat; bs_ready low outside IDLE/WR.
module icap_seq_ctrl
  import icap_pkg::*;
#(
  parameter int BITSWAP  = 1,
  parameter int READ_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bs_valid,
  input  logic [31:0] bs_data,
  input  logic        bs_last,
  output logic        bs_ready,
  output logic        busy,
  output logic        done,
  output logic        crc_err,
  output logic [31:0] stat_word,
  output logic        icap_csib,
  output logic        icap_rdwrb,
  output logic [31:0] icap_i,
  input  logic [31:0] icap_o
);

  localparam logic [2:0] RD_LAST = 3'(READ_LAT - 1);

  state_t               state, state_nxt;
  logic [ROM_IDX_W-1:0] idx_q, idx_nxt;
  logic [2:0]           rd_cnt, rd_cnt_nxt;
  logic                 csib_nxt, rdwrb_nxt, ready_nxt, busy_nxt, done_nxt, crc_nxt;
  logic [31:0]          icap_i_nxt, stat_nxt, rom_word;
  logic                 accept;

  function automatic logic [31:0] swap(input logic [31:0] x);
    return (BITSWAP != 0) ? bitswap32(x) : x;
  endfunction

  icap_cmd_rom u_rom (
    .idx  (idx_q),
    .word (rom_word)
  );

  assign accept = bs_valid & bs_ready;

  // Each state computes the registered outputs for the following cycle, so the
  // ICAP pins lag the state register by one cycle.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx_q;
    rd_cnt_nxt = rd_cnt;
    csib_nxt   = 1'b1;
    rdwrb_nxt  = icap_rdwrb;
    icap_i_nxt = icap_i;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    crc_nxt    = crc_err;
    stat_nxt   = stat_word;

    case (state)
      S_IDLE: begin
        if (accept) begin
          icap_i_nxt = swap(bs_data);
          csib_nxt   = 1'b0;
          busy_nxt   = 1'b1;
          crc_nxt    = 1'b0;
          state_nxt  = bs_last ? S_GAP : S_WR;
        end
      end
      S_WR: begin
        if (accept) begin
          icap_i_nxt = swap(bs_data);
          csib_nxt   = 1'b0;
          if (bs_last) state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        idx_nxt   = CMD_FIRST;
        state_nxt = S_CMD;
      end
      S_CMD: begin
        icap_i_nxt = swap(rom_word);
        csib_nxt   = 1'b0;
        rdwrb_nxt  = 1'b0;
        idx_nxt    = idx_q + 1'b1;
        if (idx_q == CMD_LAST) state_nxt = S_SW1;
      end
      S_SW1: begin
        rd_cnt_nxt = 3'd0;
        state_nxt  = S_RD;
      end
      S_RD: begin
        // rdwrb rises together with the first read strobe, after a csib=1 cycle.
        csib_nxt  = 1'b0;
        rdwrb_nxt = 1'b1;
        if (rd_cnt == RD_LAST) begin
          state_nxt = S_SW2;
        end else begin
          rd_cnt_nxt = rd_cnt + 1'b1;
        end
      end
      S_SW2: begin
        // icap_o now holds the word for the last visible read strobe.
        stat_nxt  = swap(icap_o);
        crc_nxt   = stat_nxt[0];
        idx_nxt   = DSY_FIRST;
        state_nxt = S_DSY;
      end
      S_DSY: begin
        icap_i_nxt = swap(rom_word);
        csib_nxt   = 1'b0;
        rdwrb_nxt  = 1'b0;
        idx_nxt    = idx_q + 1'b1;
        if (idx_q == DSY_LAST) state_nxt = S_FIN;
      end
      S_FIN: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    ready_nxt = (state_nxt == S_IDLE) || (state_nxt == S_WR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx_q      <= '0;
      rd_cnt     <= '0;
      icap_csib  <= 1'b1;
      icap_rdwrb <= 1'b0;
      icap_i     <= '0;
      bs_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      crc_err    <= 1'b0;
      stat_word  <= '0;
    end else begin
      state      <= state_nxt;
      idx_q      <= idx_nxt;
      rd_cnt     <= rd_cnt_nxt;
      icap_csib  <= csib_nxt;
      icap_rdwrb <= rdwrb_nxt;
      icap_i     <= icap_i_nxt;
      bs_ready   <= ready_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      crc_err    <= crc_nxt;
      stat_word  <= stat_nxt;
    end
  end

endmodule

// File: tb/tb_icap_seq_ctrl.sv
// Bench for icap_seq_ctrl: three instances (READ_LAT 3/1/7, one without bit swap) share one
// bitstream source; an ICAP model logs writes and answers STAT reads.
module tb_icap_seq_ctrl;

  localparam int N = 3;
  localparam int LOGSZ = 2048;
  localparam logic [31:0] SEQ [9] = '{32'hAA995566, 32'h20000000, 32'h2800E001,
                                      32'h20000000, 32'h20000000, 32'h30008001,
                                      32'h0000000D, 32'h20000000, 32'h20000000};

  typedef struct {
    logic [31:0] din;
    logic [31:0] exp_i;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          bs_valid, bs_last;
  logic [31:0]   bs_data;
  logic [N-1:0]  bs_ready, busy, done, crc_err, csib, rdwrb;
  logic [31:0]   stat_word [N];
  logic [31:0]   icap_i [N];
  logic [31:0]   icap_o [N];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] stat_val = 32'h0;

  logic [31:0] wlog [N][LOGSZ];
  int          wcyc [N][LOGSZ];
  int          wn [N], rdn [N], rdcyc [N], done_cnt [N], done_cyc [N];
  int          rule_bad [N], starts [N];
  logic        crc_start [N];
  logic [N-1:0] pcsib, prdwrb, pbusy;

  logic [31:0] pre_d [16];
  int          pre_n;
  int          last_base [N];
  int          last_t0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    icap_seq_ctrl #(
      .BITSWAP  ((g == 1) ? 0 : 1),
      .READ_LAT ((g == 0) ? 3 : ((g == 1) ? 1 : 7))
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .bs_valid   (bs_valid),
      .bs_data    (bs_data),
      .bs_last    (bs_last),
      .bs_ready   (bs_ready[g]),
      .busy       (busy[g]),
      .done       (done[g]),
      .crc_err    (crc_err[g]),
      .stat_word  (stat_word[g]),
      .icap_csib  (csib[g]),
      .icap_rdwrb (rdwrb[g]),
      .icap_i     (icap_i[g]),
      .icap_o     (icap_o[g])
    );
  end

  initial forever #5 clk = ~clk;

  function automatic int rl_of(input int k);
    return (k == 0) ? 3 : ((k == 1) ? 1 : 7);
  endfunction

  function automatic bit bsw_of(input int k);
    return (k != 1);
  endfunction

  // Bit i of the word lands on the mirrored position within its own byte.
  function automatic logic [31:0] mswap(input logic [31:0] x, input bit en);
    logic [31:0] y;
    if (!en) return x;
    for (int i = 0; i < 32; i++) y[(i / 8) * 8 + (7 - (i % 8))] = x[i];
    return y;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ICAP model and pin monitor: the STAT word is only valid on the READ_LAT-th
  // consecutive read strobe, its complement otherwise.
  initial begin
    for (int k = 0; k < N; k++) begin
      wn[k] = 0; rdn[k] = 0; rdcyc[k] = 0; done_cnt[k] = 0; done_cyc[k] = 0;
      rule_bad[k] = 0; starts[k] = 0; crc_start[k] = 1'b0; icap_o[k] = 32'h0;
    end
    pcsib = '1; prdwrb = '0; pbusy = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < N; k++) begin
        if (!pcsib[k] && (rdwrb[k] !== prdwrb[k])) rule_bad[k]++;
        if (!csib[k] && rdwrb[k]) begin
          rdn[k]++;
          rdcyc[k]++;
        end else begin
          rdn[k] = 0;
        end
        icap_o[k] = (rdn[k] == rl_of(k)) ? mswap(stat_val, bsw_of(k)) : ~mswap(stat_val, bsw_of(k));
        if (!csib[k] && !rdwrb[k]) begin
          wlog[k][wn[k] % LOGSZ] = icap_i[k];
          wcyc[k][wn[k] % LOGSZ] = cyc;
          wn[k]++;
        end
        if (done[k]) begin
          done_cnt[k]++;
          done_cyc[k] = cyc;
        end
        if (busy[k] && !pbusy[k]) begin
          starts[k]++;
          crc_start[k] = crc_err[k];
        end
      end
      pcsib = csib; prdwrb = rdwrb; pbusy = busy;
    end
  end

  // mode 0: always valid, 1: valid one cycle in three, 2: random valid.
  task automatic beat(input logic [31:0] d, input logic l, input int mode, output int t);
    int  tries = 0;
    logic v;
    forever begin
      @(negedge clk);
      v = (mode == 0) || (mode == 1 && (cyc % 3) == 0) || (mode == 2 && $urandom_range(0, 1) == 1);
      bs_valid = v;
      bs_data  = v ? d : $urandom;
      bs_last  = v ? l : 1'($urandom_range(0, 1));
      if (v && (&bs_ready)) begin
        t = cyc;
        break;
      end
      tries++;
      if (tries > 60) begin
        check("handshake_timeout", 32'(bs_ready), 32'd7);
        t = cyc;
        break;
      end
    end
  endtask

  task automatic run_stream(input int n, input int mode, input logic [31:0] stat, input string tag);
    int          t;
    bit          all;
    int          b_rd [N], b_done [N], b_rule [N], b_starts [N];
    logic [31:0] d [16];
    logic [31:0] ew;
    stat_val = stat;
    for (int k = 0; k < N; k++) begin
      last_base[k] = wn[k]; b_rd[k] = rdcyc[k]; b_done[k] = done_cnt[k];
      b_rule[k] = rule_bad[k]; b_starts[k] = starts[k];
    end
    for (int i = 0; i < n; i++) begin
      d[i] = (i < pre_n) ? pre_d[i] : $urandom;
      beat(d[i], (i == n - 1), mode, t);
      if (i == 0) last_t0 = t;
    end
    // Source keeps offering junk while the sequencer owns the ICAP.
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      check($sformatf("%s_ready_low", tag), 32'(bs_ready), 32'd0);
      bs_valid = 1'b1;
      bs_data  = $urandom;
      bs_last  = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    bs_valid = 1'b0;
    for (int w = 0; w < 60; w++) begin
      all = 1;
      for (int k = 0; k < N; k++) if (done_cnt[k] == b_done[k]) all = 0;
      if (all) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s_done_pulses_k%0d", tag, k), 32'(done_cnt[k] - b_done[k]), 32'd1);
      check($sformatf("%s_done_cycle_k%0d", tag, k), 32'(done_cyc[k]), 32'(t + 14 + rl_of(k)));
      check($sformatf("%s_nwrites_k%0d", tag, k), 32'(wn[k] - last_base[k]), 32'(n + 9));
      for (int i = 0; i < n + 9; i++) begin
        ew = (i < n) ? mswap(d[i], bsw_of(k)) : mswap(SEQ[i - n], bsw_of(k));
        check($sformatf("%s_word%0d_k%0d", tag, i, k), wlog[k][(last_base[k] + i) % LOGSZ], ew);
      end
      check($sformatf("%s_rd_cycles_k%0d", tag, k), 32'(rdcyc[k] - b_rd[k]), 32'(rl_of(k)));
      check($sformatf("%s_stat_k%0d", tag, k), stat_word[k], stat);
      check($sformatf("%s_crc_k%0d", tag, k), 32'(crc_err[k]), 32'(stat[0]));
      check($sformatf("%s_starts_k%0d", tag, k), 32'(starts[k] - b_starts[k]), 32'd1);
      check($sformatf("%s_crc_at_start_k%0d", tag, k), 32'(crc_start[k]), 32'd0);
      check($sformatf("%s_busy_end_k%0d", tag, k), 32'(busy[k]), 32'd0);
      check($sformatf("%s_rdwrb_rule_k%0d", tag, k), 32'(rule_bad[k] - b_rule[k]), 32'd0);
    end
  endtask

  initial begin
    vec_t tbl [4];
    tbl[0] = '{32'h00000001, 32'h00000080};
    tbl[1] = '{32'h80000000, 32'h01000000};
    tbl[2] = '{32'h0000FF00, 32'h0000FF00};
    tbl[3] = '{32'h12345678, 32'h482C6A1E};

    rst = 1'b1; bs_valid = 1'b0; bs_data = 32'h0; bs_last = 1'b0; pre_n = 0;
    repeat (3) @(negedge clk);
    check("rst_csib", 32'(csib), 32'd7);
    check("rst_rdwrb", 32'(rdwrb), 32'd0);
    check("rst_ready", 32'(bs_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_crc", 32'(crc_err), 32'd0);
    for (int k = 0; k < N; k++) begin
      check($sformatf("rst_icap_i_k%0d", k), icap_i[k], 32'h0);
      check($sformatf("rst_stat_k%0d", k), stat_word[k], 32'h0);
    end
    rst = 1'b0;

    for (int i = 0; i < 4; i++) pre_d[i] = tbl[i].din;
    pre_n = 4;
    run_stream(4, 0, 32'h0, "tbl");
    pre_n = 0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("tbl_icap_i_%0d", i), wlog[0][(last_base[0] + i) % LOGSZ], tbl[i].exp_i);
      check($sformatf("tbl_cycle_%0d", i), 32'(wcyc[0][(last_base[0] + i) % LOGSZ]), 32'(last_t0 + 1 + i));
    end

    run_stream(5, 1, 32'h00000001, "gap");
    run_stream(3, 2, 32'h00000000, "clr");
    run_stream(1, 0, $urandom, "single");

    begin
      int t;
      int b_done [N];
      for (int k = 0; k < N; k++) b_done[k] = done_cnt[k];
      for (int i = 0; i < 3; i++) beat($urandom, 1'b0, 0, t);
      @(negedge clk);
      rst = 1'b1; bs_valid = 1'b1; bs_data = $urandom; bs_last = 1'b0;
      @(negedge clk);
      check("abort_csib", 32'(csib), 32'd7);
      check("abort_rdwrb", 32'(rdwrb), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ready", 32'(bs_ready), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      rst = 1'b0; bs_valid = 1'b0;
      repeat (30) @(negedge clk);
      for (int k = 0; k < N; k++)
        check($sformatf("abort_no_done_k%0d", k), 32'(done_cnt[k] - b_done[k]), 32'd0);
    end
    run_stream(2, 0, $urandom, "post_rst");

    for (int r = 0; r < 8; r++)
      run_stream($urandom_range(1, 10), $urandom_range(0, 2), $urandom, $sformatf("rnd%0d", r));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
